io_port_controller: RTL

IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

---
 rtl/io_pkg.sv | 39 +++
 rtl/io_port_controller_debouncer.sv | 59 +++++
 rtl/io_port_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants and helpers for the IO port controller.
package io_pkg;

  // io_dir request encodings; 00 and 11 are no-ops.
  localparam logic [1:0] IO_DIR_IN  = 2'b01;
  localparam logic [1:0] IO_DIR_OUT = 2'b10;

  // IN FSM encodings.
  localparam logic [0:0] IN_IDLE = 1'b0;
  localparam logic [0:0] IN_WAIT = 1'b1;

  // OUT FSM encodings.
  localparam logic [1:0] OUT_IDLE = 2'd0;
  localparam logic [1:0] OUT_CONV = 2'd1;
  localparam logic [1:0] OUT_LOAD = 2'd2;

  // Largest value the three-digit display can show.
  localparam int unsigned MAX_DISPLAY = 999;

  // Default number of stable samples needed to accept a button change.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Clamp an unsigned OUT operand into the displayable range.
  function automatic logic [9:0] clamp_display(input logic [31:0] v);
    if (v > 32'(MAX_DISPLAY)) return 10'(MAX_DISPLAY);
    return v[9:0];
  endfunction

  // One double-dabble step on {bcd[11:0], bin[9:0]}: fix up digits >= 5, then shift.
  function automatic logic [21:0] dabble_step(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    if (t[21:18] >= 4'd5) t[21:18] = t[21:18] + 4'd3;
    if (t[17:14] >= 4'd5) t[17:14] = t[17:14] + 4'd3;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    return {t[20:0], 1'b0};
  endfunction

endpackage

// File: rtl/io_port_controller_debouncer.sv
// Button synchronizer, debouncer and rising-edge detector.
module button_debouncer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic press_o,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], button_i};
  end

  // Count consecutive samples that differ from the accepted level; flip after enough.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q[1] == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      state_d = sync_q[1];
      cnt_d   = '0;
      press_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
  assign level_o = state_q;

endmodule

// File: rtl/io_port_controller.sv
// IO port controller: button-gated IN of switches, OUT to a 3-digit BCD display.
//
// Handshake: io_req is a single-cycle strobe that qualifies io_dir and wr_data on
// the same rising edge; there is no ready back-channel. The CPU must hold while
// stall is high; an OUT strobe while out_busy is high is dropped and flagged.
module io_port_controller
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int IN_WIDTH        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_req,
  input  logic [1:0]          io_dir,
  input  logic [31:0]         wr_data,
  input  logic [IN_WIDTH-1:0] switches,
  input  logic                button,
  output logic [31:0]         rd_data,
  output logic                in_done,
  output logic                stall,
  output logic                in_wait,
  output logic                out_busy,
  output logic [3:0]          units,
  output logic [3:0]          tens,
  output logic [3:0]          hundreds,
  output logic                sat,
  output logic                overrun,
  output logic [0:0]          dbg_in_state,
  output logic [1:0]          dbg_out_state
);

  logic btn_press;
  logic btn_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk      (clk),
    .reset    (reset),
    .button_i (button),
    .press_o  (btn_press),
    .level_o  (btn_level)
  );

  wire in_req  = io_req && (io_dir == IO_DIR_IN);
  wire out_req = io_req && (io_dir == IO_DIR_OUT);

  logic [0:0]  in_state_q;
  logic [31:0] rd_data_q;
  logic        in_done_q;

  // IN FSM: wait for an accepted press, then capture the switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state_q <= IN_IDLE;
      rd_data_q  <= '0;
      in_done_q  <= 1'b0;
    end else begin
      in_done_q <= 1'b0;
      case (in_state_q)
        IN_IDLE: if (in_req) in_state_q <= IN_WAIT;
        IN_WAIT: if (btn_press) begin
          in_state_q <= IN_IDLE;
          rd_data_q  <= 32'(switches);
          in_done_q  <= 1'b1;
        end
        default: in_state_q <= IN_IDLE;
      endcase
    end
  end

  logic [1:0]  out_state_q;
  logic [21:0] dd_q;
  logic [3:0]  iter_q;
  logic [11:0] digits_q;
  logic        sat_q;
  logic        overrun_q;

  // OUT FSM: clamp, run 10 double-dabble steps, then load all digits at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state_q <= OUT_IDLE;
      dd_q        <= '0;
      iter_q      <= '0;
      digits_q    <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (out_req && (out_state_q != OUT_IDLE)) overrun_q <= 1'b1;
      case (out_state_q)
        OUT_IDLE: if (out_req) begin
          out_state_q <= OUT_CONV;
          dd_q        <= {12'd0, clamp_display(wr_data)};
          sat_q       <= (wr_data > 32'(MAX_DISPLAY));
          iter_q      <= '0;
        end
        OUT_CONV: begin
          dd_q   <= dabble_step(dd_q);
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd9) out_state_q <= OUT_LOAD;
        end
        OUT_LOAD: begin
          digits_q    <= dd_q[21:10];
          out_state_q <= OUT_IDLE;
        end
        default: out_state_q <= OUT_IDLE;
      endcase
    end
  end

  assign rd_data       = rd_data_q;
  assign in_done       = in_done_q;
  assign in_wait       = (in_state_q == IN_WAIT);
  assign out_busy      = (out_state_q != OUT_IDLE);
  assign stall         = in_wait | out_busy;
  assign hundreds      = digits_q[11:8];
  assign tens          = digits_q[7:4];
  assign units         = digits_q[3:0];
  assign sat           = sat_q;
  assign overrun       = overrun_q;
  assign dbg_in_state  = in_state_q;
  assign dbg_out_state = out_state_q;

  wire unused_ok = btn_level;

endmodule
